// File: rtl/dac_write_sequencer.sv
// Takes DAC control words from the 200 MHz loop domain over a toggle handshake and writes them
// to the tuning DAC as slew-limited two-byte MSB-first SPI transfers with a settle gap.
module dac_write_sequencer #(
  parameter logic [15:0] RESET_CODE     = 16'h9E23,
  parameter logic [15:0] MAX_STEP       = 16'd4096,
  parameter int unsigned SETTLE_CYCLES  = 50,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        i_req_tgl,
  input  logic [15:0] i_code,
  output logic        o_ack_tgl,
  output logic [7:0]  o_spi_byte,
  output logic        o_spi_dv,
  input  logic        i_spi_ready,
  output logic [15:0] o_dac_code,
  output logic        o_busy,
  output logic [15:0] o_write_cnt,
  output logic [7:0]  o_overrun_cnt,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    StIdle,
    StSendMsb,
    StWaitMsb,
    StSendLsb,
    StWaitLsb,
    StSettle
  } state_e;

  localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic        req_evt;
  logic        pending_q;
  logic [15:0] target_q;
  logic [15:0] next_q;
  logic [15:0] timer_q;
  logic [15:0] slew;
  logic        consume;
  logic        is_wait;
  logic        xfer_go;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= i_req_tgl;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign req_evt = sync2_q ^ sync3_q;
  assign consume = (state_q == StIdle) && (pending_q || (target_q != o_dac_code));
  assign is_wait = (state_q == StWaitMsb) || (state_q == StWaitLsb);
  // The first WAIT cycle still sees the master's ready from before it took the byte.
  assign xfer_go = i_spi_ready && (!is_wait || (timer_q != 16'd0));
  assign o_busy  = (state_q != StIdle);

  // Unsigned distance is checked before stepping, so the step never wraps past 0 or 16'hFFFF.
  always_comb begin
    slew = target_q;
    if (target_q > o_dac_code) begin
      if ((target_q - o_dac_code) > MAX_STEP) slew = o_dac_code + MAX_STEP;
    end else if ((o_dac_code - target_q) > MAX_STEP) begin
      slew = o_dac_code - MAX_STEP;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      target_q      <= RESET_CODE;
      next_q        <= RESET_CODE;
      timer_q       <= '0;
      o_ack_tgl     <= 1'b0;
      o_spi_byte    <= '0;
      o_spi_dv      <= 1'b0;
      o_dac_code    <= RESET_CODE;
      o_write_cnt   <= '0;
      o_overrun_cnt <= '0;
      o_fault       <= 1'b0;
    end else begin
      o_spi_dv <= 1'b0;

      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (consume) begin
            next_q    <= slew;
            pending_q <= 1'b0;
            state_q   <= StSendMsb;
          end
        end
        StSendMsb, StWaitMsb, StSendLsb, StWaitLsb: begin
          if (xfer_go) begin
            timer_q <= '0;
            unique case (state_q)
              StSendMsb: begin
                o_spi_byte <= next_q[15:8];
                o_spi_dv   <= 1'b1;
                state_q    <= StWaitMsb;
              end
              StWaitMsb: state_q <= StSendLsb;
              StSendLsb: begin
                o_spi_byte <= next_q[7:0];
                o_spi_dv   <= 1'b1;
                state_q    <= StWaitLsb;
              end
              default: begin
                o_dac_code  <= next_q;
                o_write_cnt <= o_write_cnt + 16'd1;
                state_q     <= StSettle;
              end
            endcase
          end else if (timer_q >= TimeoutLim) begin
            // Target is left alone so IDLE retries the same step.
            o_fault <= 1'b1;
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StSettle: begin
          if (timer_q >= SettleLast) begin
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the FSM so a new word arriving as IDLE consumes keeps pending set.
      if (req_evt) begin
        target_q  <= i_code;
        pending_q <= 1'b1;
        o_ack_tgl <= sync2_q;
        if (pending_q && !consume && (o_overrun_cnt != 8'hFF)) begin
          o_overrun_cnt <= o_overrun_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed bench: a default-step instance with a simple SPI master model, plus a full-step
// instance with an always-ready master for the request-overwrite scenario.
module tb_dac_write_sequencer;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        reset;
  logic        req, ack, spi_dv, spi_ready, busy, fault;
  logic [15:0] code, dac_code, write_cnt;
  logic [7:0]  spi_byte, overrun_cnt;
  logic        w_req, w_ack, w_dv, w_ready, w_busy, w_fault;
  logic [15:0] w_code, w_dac, w_cnt;
  logic [7:0]  w_byte, w_ovr;

  logic        hold_low;
  int          busy_cnt;
  logic [7:0]  bytes[$];
  logic [7:0]  w_bytes[$];
  int          n_tests = 0;
  int          n_fail = 0;

  dac_write_sequencer u_dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .i_req_tgl    (req),
    .i_code       (code),
    .o_ack_tgl    (ack),
    .o_spi_byte   (spi_byte),
    .o_spi_dv     (spi_dv),
    .i_spi_ready  (spi_ready),
    .o_dac_code   (dac_code),
    .o_busy       (busy),
    .o_write_cnt  (write_cnt),
    .o_overrun_cnt(overrun_cnt),
    .o_fault      (fault)
  );

  dac_write_sequencer #(.MAX_STEP(16'hFFFF)) u_dut_wide (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .i_req_tgl    (w_req),
    .i_code       (w_code),
    .o_ack_tgl    (w_ack),
    .o_spi_byte   (w_byte),
    .o_spi_dv     (w_dv),
    .i_spi_ready  (w_ready),
    .o_dac_code   (w_dac),
    .o_busy       (w_busy),
    .o_write_cnt  (w_cnt),
    .o_overrun_cnt(w_ovr),
    .o_fault      (w_fault)
  );

  // SPI master model: logs each byte and stays busy for a few cycles after it.
  always @(negedge CLOCK_50) begin
    if (reset && spi_dv) begin
      bytes.push_back(spi_byte);
      busy_cnt = 6;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
    end
    if (!reset) busy_cnt = 0;
    spi_ready = (busy_cnt == 0) && !hold_low;
    if (reset && w_dv) w_bytes.push_back(w_byte);
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input logic sel, input string tag, input int n,
                             input logic [63:0] exp);
    check({tag, " nbytes"}, sel ? w_bytes.size() : bytes.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] g;
      g = 'x;
      if (sel && i < w_bytes.size()) g = w_bytes[i];
      if (!sel && i < bytes.size()) g = bytes[i];
      check($sformatf("%s byte%0d", tag, i), g, exp[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req      = 1'b0;
    w_req    = 1'b0;
    hold_low = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    bytes.delete();
    w_bytes.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " dac"}, dac_code, 16'h9E23);
    check({tag, " dv"}, spi_dv, 1'b0);
    check({tag, " byte"}, spi_byte, 8'h00);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " wcnt"}, write_cnt, 16'd0);
    check({tag, " ovr"}, overrun_cnt, 8'd0);
    check({tag, " ack"}, ack, 1'b0);
    check({tag, " fault"}, fault, 1'b0);
  endtask

  task automatic send_req(input logic sel, input logic [15:0] c, input string tag);
    if (sel) begin
      w_code = c;
      w_req  = ~w_req;
    end else begin
      code = c;
      req  = ~req;
    end
    for (int i = 0; i < 4 && ((sel ? w_ack : ack) != (sel ? w_req : req)); i++) tick();
    check({tag, " ack"}, sel ? w_ack : ack, sel ? w_req : req);
  endtask

  task automatic wait_writes(input logic sel, input logic [15:0] n, input string tag);
    for (int i = 0; i < 3000 && ((sel ? w_cnt : write_cnt) != n); i++) tick();
    check(tag, sel ? w_cnt : write_cnt, n);
  endtask

  initial begin
    reset   = 1'b0;
    code    = '0;
    w_code  = '0;
    w_ready = 1'b1;
    busy_cnt = 0;
    do_reset();
    check_reset("rst");

    // Single small step completes in one write.
    send_req(1'b0, 16'h9E30, "t1");
    wait_writes(1'b0, 16'd1, "t1 wcnt");
    repeat (100) tick();
    check("t1 dac", dac_code, 16'h9E30);
    check("t1 wcnt final", write_cnt, 16'd1);
    check_bytes(1'b0, "t1", 2, 64'h9E30);

    // Large move is split into MAX_STEP-limited steps without further requests.
    do_reset();
    send_req(1'b0, 16'hC000, "t2");
    wait_writes(1'b0, 16'd3, "t2 wcnt");
    repeat (100) tick();
    check("t2 dac", dac_code, 16'hC000);
    check("t2 wcnt final", write_cnt, 16'd3);
    check_bytes(1'b0, "t2", 6, 64'hAE23BE23C000);

    // Writing the current value still performs one write.
    do_reset();
    send_req(1'b0, 16'h9E23, "t6");
    wait_writes(1'b0, 16'd1, "t6 wcnt");
    repeat (100) tick();
    check("t6 wcnt final", write_cnt, 16'd1);
    check_bytes(1'b0, "t6", 2, 64'h9E23);

    // SPI ready stuck low after the MSB: timeout, then retry once released.
    do_reset();
    send_req(1'b0, 16'h9E40, "t4");
    for (int i = 0; i < 50 && bytes.size() < 1; i++) tick();
    check("t4 first byte", bytes.size(), 1);
    hold_low = 1'b1;
    repeat (2100) tick();
    check("t4 fault", fault, 1'b1);
    check("t4 dac held", dac_code, 16'h9E23);
    check("t4 wcnt held", write_cnt, 16'd0);
    hold_low = 1'b0;
    wait_writes(1'b0, 16'd1, "t4 retry wcnt");
    check("t4 dac", dac_code, 16'h9E40);
    check("t4 fault sticky", fault, 1'b1);

    // Reset during WAIT_LSB.
    do_reset();
    send_req(1'b0, 16'h1234, "t5");
    for (int i = 0; i < 50 && bytes.size() < 2; i++) tick();
    check("t5 lsb sent", bytes.size(), 2);
    check("t5 busy", busy, 1'b1);
    reset = 1'b0;
    req   = 1'b0;
    tick();
    check_reset("t5");
    reset = 1'b1;
    repeat (80) tick();
    check("t5 no dv", bytes.size(), 2);
    check("t5 dac", dac_code, 16'h9E23);

    // Overwritten requests on the full-step instance: only the latest word is written next.
    do_reset();
    send_req(1'b1, 16'h1000, "t3a");
    for (int i = 0; i < 20 && w_bytes.size() < 1; i++) tick();
    check("t3 started", w_busy, 1'b1);
    send_req(1'b1, 16'h2000, "t3b");
    send_req(1'b1, 16'h3000, "t3c");
    wait_writes(1'b1, 16'd2, "t3 wcnt");
    repeat (100) tick();
    check("t3 wcnt final", w_cnt, 16'd2);
    check("t3 dac", w_dac, 16'h3000);
    check("t3 ovr", w_ovr, 8'd1);
    check("t3 fault", w_fault, 1'b0);
    check_bytes(1'b1, "t3", 4, 64'h10003000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_write_sequencer.md
# dac_write_sequencer

Sits directly downstream of the DPLL loop filter: it takes each new 16-bit DAC control word produced in the 200 MHz loop domain and writes it to the oscillator-tuning DAC. The word crosses into CLOCK_50 over a toggle handshake. Each step is slew-limited so no single write moves the DAC by more than MAX_STEP codes. The block sequences the two-byte MSB-first transfer through the single-CS SPI master and enforces a settle gap between writes.

## Interface
- RESET_CODE, 16'h9E23, DAC word assumed present at reset; first write targets start from it
- MAX_STEP, 16'd4096, max |change| of DAC code per SPI write; must be ≥1
- SETTLE_CYCLES, 50, CLOCK_50 cycles of idle gap after a write completes
- TIMEOUT_CYCLES, 2000, max cycles to wait for SPI ready per byte
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  reset, synchronous, active-low; clock CLOCK_50
- i_req_tgl  in  1  request toggle from 200 MHz domain; each transition = new word on i_code
- i_code  in  16  target DAC word; source holds it stable from i_req_tgl toggle until o_ack_tgl matches
- o_ack_tgl  out  1  acknowledge toggle; set equal to synchronized i_req_tgl when i_code captured
- o_spi_byte  out  8  byte to SPI master
- o_spi_dv  out  1  one-cycle byte-valid strobe to SPI master
- i_spi_ready  in  1  SPI master ready
- o_dac_code  out  16  last code fully written to the DAC
- o_busy  out  1  high in any state other than IDLE
- o_write_cnt  out  16  completed two-byte writes, wraps at 16'hFFFF→0
- o_overrun_cnt  out  8  requests overwritten before being written, saturates at 8'hFF
- o_fault  out  1  sticky SPI-timeout flag, cleared only by reset

## Operation
- CDC: i_req_tgl passes through a 2-flop synchronizer, then a third flop for edge detect; req_evt = sync2 ^ sync3.
- On req_evt:
  - i_code is captured into target and pending is set.
  - o_ack_tgl <= sync2.
  - If pending was already set and not yet consumed, o_overrun_cnt increments; the latest word wins.
- Slew computation, unsigned 16-bit, no wrap:
  - next = target when |target − o_dac_code| ≤ MAX_STEP.
  - Otherwise next = o_dac_code ± MAX_STEP toward target.
- FSM states:
  - IDLE: when pending or target ≠ o_dac_code, compute next, clear pending, go to SEND_MSB.
  - SEND_MSB: wait for i_spi_ready=1, then drive o_spi_byte = next[15:8], pulse o_spi_dv, go to WAIT_MSB.
  - WAIT_MSB: ignore ready on the first cycle, then wait for i_spi_ready=1 and go to SEND_LSB.
  - SEND_LSB: same as SEND_MSB with next[7:0]; go to WAIT_LSB.
  - WAIT_LSB: same as WAIT_MSB. On ready: o_dac_code <= next, o_write_cnt++, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to IDLE. If target still differs, IDLE immediately starts the next slew step with no new request.
- Timeout: in any SEND or WAIT state, if the wait exceeds TIMEOUT_CYCLES:
  - set o_fault and go to IDLE;
  - o_dac_code is not updated;
  - target is kept, so IDLE retries.
- A req_evt arriving in any state only updates target/pending; it never aborts a transfer in flight.

## Timing
- Reset values:
  - o_dac_code = target = RESET_CODE.
  - o_ack_tgl = 0, o_spi_dv = 0, o_spi_byte = 0.
  - o_busy = 0, o_write_cnt = 0, o_overrun_cnt = 0, o_fault = 0.
  - Synchronizer flops = 0 and pending = 0, so no write occurs after reset.
- Reset asserted mid-transfer: the FSM goes to IDLE on the next edge and o_spi_dv drops. The SPI master shares the reset.
- Request latency:
  - i_req_tgl edge → req_evt: 3 CLOCK_50 edges.
  - o_ack_tgl: updates on the same edge that pending is set.
  - First o_spi_dv: ≤2 cycles after that when idle and ready=1.
- o_spi_dv is exactly 1 cycle wide, and o_spi_byte is valid in the same cycle.
- o_dac_code and o_write_cnt update together, one edge after ready is observed in WAIT_LSB.
- Minimum spacing between first-byte o_spi_dv pulses = transfer time + SETTLE_CYCLES + 2.
- req_evt in the same cycle that IDLE consumes pending: the new word is captured, pending stays set, and o_overrun_cnt does not increment.

## Test plan
- Reset, then toggle i_req_tgl with i_code=16'h9E30:
  - exactly one write: bytes 0x9E then 0x30;
  - o_dac_code = 16'h9E30, o_write_cnt = 1;
  - o_ack_tgl = 1 within 4 cycles of the toggle.
- i_code=16'hC000 from RESET_CODE with MAX_STEP=4096 → writes 0xAE23, 0xBE23, then 0xC000; o_write_cnt = 3.
- Three toggles (codes 0x1000, 0x2000, 0x3000) inside one transfer with MAX_STEP=16'hFFFF → only the final 0x3000 is written next; o_overrun_cnt = 1.
- Hold i_spi_ready=0 in WAIT_MSB longer than TIMEOUT_CYCLES:
  - o_fault = 1 and o_dac_code unchanged;
  - after ready is released, a retry completes the write.
- Assert reset in WAIT_LSB → all outputs return to their reset values next edge, no further o_spi_dv, o_dac_code = 16'h9E23.
- Toggle with i_code equal to o_dac_code → one write of the same value; o_write_cnt increments by 1.
